// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser.
// Contents:
//   coin_code_t  - 2-bit coin code carried on RRo[1:0]
//   VAL_*        - unit value of each coin code
//   ACK_TIMEOUT  - EJECT cycles to wait for coin_ack before faulting a tube
//   state_t      - dispenser FSM states
//   coin_value() - maps a coin code to its unit value
package vend_pkg;

   typedef enum logic [1:0] {
      COIN_1  = 2'd0,
      COIN_5  = 2'd1,
      COIN_10 = 2'd2,
      COIN_25 = 2'd3
   } coin_code_t;

   localparam logic [7:0] VAL_1  = 8'd1;
   localparam logic [7:0] VAL_5  = 8'd5;
   localparam logic [7:0] VAL_10 = 8'd10;
   localparam logic [7:0] VAL_25 = 8'd25;

   localparam logic [3:0] ACK_TIMEOUT = 4'd15;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      EJECT  = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic logic [7:0] coin_value(input logic [1:0] code);
      case (coin_code_t'(code))
         COIN_25: coin_value = VAL_25;
         COIN_10: coin_value = VAL_10;
         COIN_5:  coin_value = VAL_5;
         COIN_1:  coin_value = VAL_1;
         default: coin_value = VAL_1;
      endcase
   endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Refund request / hopper bus of the change dispenser.
// Signals:
//   rr        - refund request (master -> dispenser)
//   amount    - refund value in units, captured with rr
//   empty     - per-tube empty flags, bit i for coin code i
//   coin_ack  - hopper confirms one coin ejected
//   RRo       - {coin_valid, coin_code[1:0]} to the hopper
//   busy      - dispenser not in IDLE
//   done      - one-cycle completion pulse
//   short     - change could not be fully paid (valid with done)
//   remaining - value still owed
// Modports: master drives requests/acks, slave is the dispenser.
interface change_dispenser_if;
   logic       rr;
   logic [7:0] amount;
   logic [3:0] empty;
   logic       coin_ack;
   logic [2:0] RRo;
   logic       busy;
   logic       done;
   logic       short;
   logic [7:0] remaining;

   modport master (
      output rr, amount, empty, coin_ack,
      input  RRo, busy, done, short, remaining
   );

   modport slave (
      input  rr, amount, empty, coin_ack,
      output RRo, busy, done, short, remaining
   );
endinterface

// File: rtl/change_dispenser_ack_timer.sv
// ack_timer: 4-bit EJECT watchdog.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   clear   - synchronous clear to zero (dominates enable)
//   enable  - count one cycle
//   expired - high during the last permitted waiting cycle
module ack_timer
(
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   import vend_pkg::*;

   logic [3:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + 4'd1;
   end

   // Count starts at 0 in the first EJECT cycle, so the value
   // ACK_TIMEOUT-1 marks the ACK_TIMEOUT-th cycle spent waiting.
   assign expired = enable && (count == (ACK_TIMEOUT - 4'd1));

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays a refund with the fewest coins available.
// Ports:
//   CLK   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - change_dispenser_if.slave (rr/amount/empty/coin_ack in,
//           RRo/busy/done/short/remaining out)
// Greedy selection: the highest-value coin that fits the remaining
// amount and whose tube is neither empty nor faulted is ejected next.
// A tube that never acknowledges within ACK_TIMEOUT cycles is faulted
// for the rest of the current refund.
module change_dispenser
(
   input  logic               CLK,
   input  logic               reset,
   change_dispenser_if.slave  bus
);
   import vend_pkg::*;

   state_t     state, state_nx;
   logic [7:0] rem_q, rem_nx;
   logic [3:0] fault_q, fault_nx;
   logic [1:0] code_q, code_nx;
   logic       short_q, short_nx;

   logic       tmr_clear;
   logic       tmr_en;
   logic       tmr_expired;

   logic       pick_ok;
   logic [1:0] pick_code;

   ack_timer u_ack_timer (
      .clk     (CLK),
      .rst_n   (reset),
      .clear   (tmr_clear),
      .enable  (tmr_en),
      .expired (tmr_expired)
   );

   // Ascending scan: a later (higher) qualifying code overrides a lower one.
   // A zero remainder never qualifies since every coin is worth >= 1.
   always_comb begin
      pick_ok   = 1'b0;
      pick_code = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!bus.empty[i] && !fault_q[i] && (coin_value(2'(i)) <= rem_q)) begin
            pick_ok   = 1'b1;
            pick_code = 2'(i);
         end
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         rem_q   <= '0;
         fault_q <= '0;
         code_q  <= '0;
         short_q <= 1'b0;
      end else begin
         state   <= state_nx;
         rem_q   <= rem_nx;
         fault_q <= fault_nx;
         code_q  <= code_nx;
         short_q <= short_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      rem_nx    = rem_q;
      fault_nx  = fault_q;
      code_nx   = code_q;
      short_nx  = short_q;
      tmr_clear = 1'b1;
      tmr_en    = 1'b0;

      case (state)
         IDLE: begin
            if (bus.rr) begin
               rem_nx   = bus.amount;
               fault_nx = '0;
               short_nx = 1'b0;
               state_nx = (bus.amount != '0) ? SELECT : DONE;
            end
         end

         SELECT: begin
            if (pick_ok) begin
               code_nx  = pick_code;
               state_nx = EJECT;
            end else begin
               short_nx = (rem_q != '0);
               state_nx = DONE;
            end
         end

         EJECT: begin
            tmr_clear = 1'b0;
            tmr_en    = 1'b1;
            // An ack on the timeout cycle still counts as a paid coin.
            if (bus.coin_ack) begin
               rem_nx    = rem_q - coin_value(code_q);
               tmr_clear = 1'b1;
               state_nx  = SELECT;
            end else if (tmr_expired) begin
               fault_nx[code_q] = 1'b1;
               tmr_clear        = 1'b1;
               state_nx         = SELECT;
            end
         end

         DONE: begin
            state_nx = IDLE;
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign bus.RRo       = (state == EJECT) ? {1'b1, code_q} : 3'b000;
   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.short     = short_q;
   assign bus.remaining = rem_q;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port rr, input, 1 bit: refund request, sampled only in IDLE.
REQ-004 SHALL have port amount, input, 8 bits: refund value in units, captured with rr.
REQ-005 SHALL have port empty, input, 4 bits: per-tube empty flags, bit i for coin code i.
REQ-006 SHALL have port coin_ack, input, 1 bit: hopper confirms that one coin was ejected.
REQ-007 SHALL have port RRo, output, 3 bits: {coin_valid, coin_code[1:0]}; bit 2 high means eject the coin of code [1:0].
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port short, output, 1 bit: the change could not be fully paid; valid while done is high.
REQ-011 SHALL have port remaining, output, 8 bits: value still owed.

Function
REQ-012 SHALL use these coin values: code 3 = 25, code 2 = 10, code 1 = 5, code 0 = 1.
REQ-013 SHALL implement FSM states IDLE, SELECT, EJECT and DONE.
REQ-014 In IDLE, when rr=1 and amount!=0, SHALL load remaining=amount, clear the fault mask and go to SELECT.
REQ-015 In IDLE, when rr=1 and amount=0, SHALL go straight to DONE with short=0 and eject no coin.
REQ-016 In SELECT, SHALL pick the highest code with value<=remaining, empty=0 and fault=0, latch that code, and go to EJECT; this takes one cycle.
REQ-017 In SELECT, when no code qualifies, SHALL go to DONE with short=(remaining!=0).
REQ-018 In EJECT, SHALL hold RRo[2]=1 and a stable RRo[1:0] until coin_ack is sampled high.
REQ-019 On the first edge in EJECT where coin_ack is sampled high, SHALL subtract the coin value from remaining, clear the timer and return to SELECT.
REQ-020 SHALL allow coin_ack in the first EJECT cycle, so that one coin costs 2 cycles (SELECT + EJECT).
REQ-021 After 15 EJECT cycles without coin_ack, SHALL set the fault bit for the latched code, drop RRo[2] and return to SELECT.
REQ-022 In DONE, SHALL assert done for exactly one cycle and return to IDLE; remaining and short hold until the next accepted rr.
REQ-023 SHALL ignore rr while busy=1.
REQ-024 SHALL ignore coin_ack outside EJECT.
REQ-025 SHALL ignore changes on empty during EJECT, because the coin selection is already committed.
REQ-026 SHALL never let the subtraction in remaining underflow, because selection guarantees value<=remaining.

Reset
REQ-027 While reset=0, SHALL immediately force state=IDLE, RRo=0, busy=0, done=0, short=0, remaining=0, fault mask=0 and timer=0.
REQ-028 A reset mid-EJECT SHALL drop RRo[2] asynchronously, SHALL NOT update remaining, and SHALL NOT raise done.
REQ-029 After reset deasserts, SHALL accept rr from the first rising edge.

Structure
REQ-030 Package vend_pkg SHALL hold the coin value constants, the coin code encoding, the FSM state enum and ACK_TIMEOUT=15.
REQ-031 SHALL instantiate one sub-module, ack_timer, a 4-bit counter with clear and enable inputs and an expired output.

Verification
REQ-032 Scenario: amount=100, empty=0, immediate ack -> RRo codes 3,3,3,3; done pulses 10 cycles after rr is sampled; short=0; remaining=0.
REQ-033 Scenario: amount=42 -> codes 3,2,1,0,0 in that order; remaining=0; short=0.
REQ-034 Scenario: amount=30, empty=4'b1000 -> codes 2,2,2; short=0.
REQ-035 Scenario: amount=7, empty=4'b0001 -> code 1 once, then done with short=1 and remaining=2.
REQ-036 Scenario: amount=25, coin_ack withheld for code 3 -> RRo[2] drops after 15 cycles, then codes 2,2,1 are issued; remaining=0.
REQ-037 Scenario: reset pulsed low during the second EJECT of amount=50 -> RRo=0 and busy=0 immediately, no done pulse, and the next rr with amount=5 yields code 1.
